reset_release_sequencer: RTL

Generates the staged, synchronously released active-low preset/reset signals that the team's asynchronous-preset flip-flops and downstream blocks consume. Raw reset assertion propagates to every output immediately. Deassertion is first synchronized to `iClock` and then held for a fixed number of cycles. The domains are then released one at a time, each waiting for the previous domain's ready handshake. The block sits at the top of each clock domain, between the board/PLL reset source and the domain's functional logic.

---
 rtl/reset_seq_pkg.sv | 42 ++++
 rtl/reset_sync_chain.sv | 25 ++
 rtl/reset_release_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encoding, width helpers and legal-parameter floors for the reset sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package reset_seq_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    stReset = 3'd0,
    stHold  = 3'd1,
    stRel   = 3'd2,
    stWait  = 3'd3,
    stDone  = 3'd4
  } seqState_t;

  // Smallest legal parameter values.
  localparam int MIN_SYNC_STAGES    = 2;
  localparam int MIN_NUM_DOMAINS    = 1;
  localparam int MIN_HOLD_CYCLES    = 1;
  localparam int MIN_TIMEOUT_CYCLES = 1;

  // Value loaded into the hold counter when leaving RESET. The edge that
  // lands in the last synchronizer stage and the edge that leaves RESET both
  // count toward the hold period, so a raw release sees oPreset[0] at edge
  // SYNC_STAGES+HOLD_CYCLES while a soft reset (no synchronizer) waits the
  // full HOLD_CYCLES+1 edges.
  localparam int HOLD_PRELOAD = 2;

  // Number of bits needed to encode values 0..value-1 (0 for value<=1).
  function automatic int clog2Int(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset deassertion synchronizer: async clear, shifts in a constant 1.
// Latency: release visible SYNC_STAGES edges after iReset goes high; assertion is immediate.
// Backpressure: none; free-running chain.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClock,
  input  logic iReset,
  output logic oRelease
);

  logic [SYNC_STAGES-1:0] stages;

  // Clear asynchronously, then walk a 1 through the chain on each edge.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign oRelease = stages[SYNC_STAGES-1];

endmodule

// File: rtl/reset_release_sequencer.sv
// Staged active-low reset release: sync, hold, then release domains in order on ready handshakes.
// Latency: oPreset[0] at edge SYNC_STAGES+HOLD_CYCLES; each next domain on the edge sampling the previous ready.
// Backpressure: a domain waits for its iReady (or the watchdog when RSTSEQ_TIMEOUT_EN is defined).
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DELAY          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                   iClock,
  input  logic                                   iReset,
  input  logic                                   iSoftReq,
  input  logic [NUM_DOMAINS-1:0]                 iReady,
  output logic [NUM_DOMAINS-1:0]                 oPreset,
  output logic                                   oDone,
  output logic                                   oTimeout,
  output logic [clog2Int(NUM_DOMAINS+1)-1:0]     oStage
);

  localparam int STAGE_W = clog2Int(NUM_DOMAINS + 1);
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? clog2Int(NUM_DOMAINS) : 1;
`ifdef RSTSEQ_TIMEOUT_EN
  localparam int CNT_SPAN = maxInt(maxInt(HOLD_CYCLES, TIMEOUT_CYCLES), HOLD_PRELOAD);
`else
  localparam int CNT_SPAN = maxInt(HOLD_CYCLES, HOLD_PRELOAD);
`endif
  localparam int CNT_W = clog2Int(CNT_SPAN + 1);

  localparam logic [CNT_W-1:0]       HOLD_LAST     = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       RESET_PRELOAD = CNT_W'(HOLD_PRELOAD);
  localparam logic [CNT_W-1:0]       CNT_ONE       = CNT_W'(1);
  localparam logic [IDX_W-1:0]       LAST_IDX      = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [IDX_W-1:0]       IDX_ONE       = IDX_W'(1);
  localparam logic [STAGE_W-1:0]     STAGE_ONE     = STAGE_W'(1);
  localparam logic [NUM_DOMAINS-1:0] PRESET_ONE    = NUM_DOMAINS'(1);
`ifdef RSTSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]       TO_LAST       = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Parameter legality, caught at elaboration.
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : gBadSync
    $error("SYNC_STAGES must be at least 2");
  end
  if (NUM_DOMAINS < MIN_NUM_DOMAINS) begin : gBadDomains
    $error("NUM_DOMAINS must be at least 1");
  end
  if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : gBadHold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < MIN_TIMEOUT_CYCLES) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (DELAY < 0) begin : gBadDelay
    $error("DELAY must not be negative");
  end

  seqState_t        state;
  logic [CNT_W-1:0] cnt;         // hold counter in HOLD, watchdog in WAIT
  logic [IDX_W-1:0] idx;         // domain currently awaiting its ready
  logic             syncRelease;
  logic             readyHit;
  logic             wdExpired;
  logic             timeoutFlag;

  reset_sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uSync (
    .iClock  (iClock),
    .iReset  (iReset),
    .oRelease(syncRelease)
  );

  // Ready of the pending domain and watchdog expiry (expiry only counts when ready is absent).
  always_comb begin
    readyHit = iReady[idx];
`ifdef RSTSEQ_TIMEOUT_EN
    wdExpired = (state == stWait) && (cnt >= TO_LAST) && !readyHit;
`else
    wdExpired = 1'b0;
`endif
  end

  // Sequencer FSM with registered outputs; released domains form a thermometer code in oPreset.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state       <= stReset;
      cnt         <= '0;
      idx         <= '0;
      oPreset     <= '0;
      oDone       <= 1'b0;
      timeoutFlag <= 1'b0;
      oStage      <= '0;
    end else begin
      case (state)
        stReset: begin
          if (syncRelease) begin
            state <= stHold;
            cnt   <= RESET_PRELOAD;
          end
        end

        stHold: begin
          if (cnt >= HOLD_LAST) begin
            state <= stRel;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        stRel: begin
          oPreset <= (oPreset << 1) | PRESET_ONE;
          oStage  <= oStage + STAGE_ONE;
          cnt     <= '0;
          state   <= stWait;
        end

        stWait: begin
          if (readyHit || wdExpired) begin
            if (wdExpired) timeoutFlag <= 1'b1;
            if (idx == LAST_IDX) begin
              oDone <= 1'b1;
              state <= stDone;
            end else begin
              // Next domain goes on the same edge that accepts this one.
              idx     <= idx + IDX_ONE;
              oPreset <= (oPreset << 1) | PRESET_ONE;
              oStage  <= oStage + STAGE_ONE;
              cnt     <= '0;
            end
          end
`ifdef RSTSEQ_TIMEOUT_EN
          else begin
            cnt <= cnt + CNT_ONE;
          end
`endif
        end

        stDone: begin
          if (iSoftReq) begin
            oPreset     <= '0;
            oStage      <= '0;
            oDone       <= 1'b0;
            timeoutFlag <= 1'b0;
            cnt         <= '0;
            state       <= stHold;
          end
        end

        default: begin
          state <= stReset;
        end
      endcase
    end
  end

  assign oTimeout = timeoutFlag;

endmodule
